ahb_decoder_ds: RTL and testbench
=================================

// Module: ahb_decoder_ds
// PURPOSE
//  Parametrised AHB address decoder with a built-in default slave. Decodes haddr
//  against SLV_NUM base/mask regions and drives one-hot hsel. Registers the
//  data-phase select that steers the interconnect's hrdata/hresp/hready mux.
//  Unmapped NONSEQ/SEQ accesses get a two-cycle AHB ERROR response, and the
//  first error address is captured. Sits in the interconnect, one instance per master.
// PARAMETERS
//  AHB_ADDR_WIDTH  32          address width
//  SLV_NUM         4           number of decoded slave regions (1..16)
//  SLV_BASE        {SLV_NUM{32'h0}} packed [SLV_NUM*AHB_ADDR_WIDTH]; region i base
//  SLV_MASK        {SLV_NUM{32'hFFFF_0000}} packed; region i compare mask
//  ERR_CNT_W       8           width of saturating error counter
//  REMAP_SLV       1           region swapped with region 0 under remap (macro only)
// PORTS
//  hclk         in   1              clock, all logic on rising edge
//  hreset       in   1              synchronous, active-high reset
//  haddr        in   AHB_ADDR_WIDTH address-phase address
//  htrans       in   htrans_type    address-phase transfer type
//  hready       in   1              bus hready (output of the response mux)
//  hsel         out  SLV_NUM        address-phase one-hot slave select (comb)
//  hsel_dp      out  SLV_NUM        registered data-phase select, slaves
//  dflt_sel_dp  out  1              registered data-phase select, default slave
//  dflt_hready  out  1              default-slave hreadyout
//  dflt_hresp   out  hresp_type     default-slave response
//  err_addr     out  AHB_ADDR_WIDTH haddr of the first unmapped access since clear
//  err_cnt      out  ERR_CNT_W      saturating count of unmapped accesses
//  err_clr      in   1              clears err_cnt and the err_addr valid flag
// BEHAVIOUR
//  - hit[i] = ((haddr & SLV_MASK[i]) == SLV_BASE[i]). On overlap, lowest i wins;
//    hit is forced one-hot.
//  - act = htrans is NONSEQ or SEQ. hsel[i] = hit[i] & (htrans != IDLE).
//  - dflt_hit = act & ~|hit. BUSY to an unmapped address gives no hsel, no error.
//  - Data-phase regs: if hready, then hsel_dp <= hsel and dflt_sel_dp <= dflt_hit;
//    otherwise hold. All zero selects nothing; the mux then returns OKAY/ready.
//  - Default-slave FSM, states DS_IDLE / DS_ERR1 / DS_ERR2:
//    DS_IDLE: dflt_hready=1, dflt_hresp=OKAY; hready&dflt_hit -> DS_ERR1.
//    DS_ERR1: dflt_hready=0, dflt_hresp=ERROR; goes -> DS_ERR2 unconditionally.
//    DS_ERR2: dflt_hready=1, dflt_hresp=ERROR; dflt_hit -> DS_ERR1, else DS_IDLE.
//  - The IDLE->ERR1 / ERR2->ERR1 transition is the error event.
//    On that event err_cnt increments, saturating at all-ones.
//    On that event err_addr latches haddr only if its valid flag is clear, then
//    sets the flag.
//  - err_clr: err_cnt <= 0 and valid <= 0. If err_clr and an error event fall in
//    the same cycle, err_clr wins for err_cnt. err_addr then takes the new address.
//  - Reset (any cycle, including mid-ERR1) sets: FSM DS_IDLE, hsel_dp=0,
//    dflt_sel_dp=0, err_cnt=0, err_addr=0, valid=0. dflt_hready=1, dflt_hresp=OKAY.
//  - Latency: hsel is 0-cycle combinational. *_dp follow 1 cycle after the
//    hready-qualified address phase. An error costs exactly 2 data-phase cycles.
// CONFIGURATION
//  AHB_DEC_REMAP_EN defined: adds input port hremap (1 bit, after htrans).
//    When hremap=1, region 0 and region REMAP_SLV swap SLV_BASE/SLV_MASK for
//    decode. hsel indices are unchanged.
//  AHB_DEC_REMAP_EN undefined: no hremap port and the map is fixed.
// STRUCTURE
//  AHB_package gains: hresp_type enum (OKAY=2'b00, ERROR=2'b01, RETRY, SPLIT),
//    the ds_state_t enum, and the helper function addr_hit(addr, base, mask).
//  htrans_type is reused from AHB_package.
//  One sub-module: ahb_default_slave (FSM + err_cnt/err_addr). The decode and the
//    data-phase registers stay in the top module.
// TESTING
//  Test config: SLV_NUM=4, mask FFFF_0000, bases 0000_0000/0001_0000/0002_0000/0003_0000.
//  T1: NONSEQ 0x0002_0040, hready=1 -> hsel=4'b0100; next cycle hsel_dp=4'b0100.
//  T2: NONSEQ 0x0009_0000 -> dflt_sel_dp=1; hready/hresp go 0/ERROR, then
//    1/ERROR, then 1/OKAY. err_cnt=1, err_addr=0x0009_0000.
//  T3: Two back-to-back unmapped NONSEQs, hready held low 3 cycles between
//    phases -> hsel_dp holds; err_cnt=2, err_addr keeps the first address.
//  T4: 300 unmapped accesses -> err_cnt saturates at 8'hFF.
//    err_clr in the same cycle as an error event -> err_cnt=0, err_addr updates.
//  T5: hreset=1 while in DS_ERR1 -> next cycle DS_IDLE, outputs at reset values.
//    BUSY/IDLE to an unmapped address -> no error.
//  T6 (AHB_DEC_REMAP_EN): hremap=1, NONSEQ 0x0000_0010 -> hsel=4'b0010.
//    With hremap=0 the same access gives hsel=4'b0001.

Source files
------------

// File: rtl/ahb_decoder_ds_pkg.sv
// -----------------------------------------------------------------------------
// ahb_decoder_ds_pkg
//   Shared AHB types for the address decoder and its default slave.
//   - htrans_type : AHB transfer type (IDLE/BUSY/NONSEQ/SEQ)
//   - hresp_type  : AHB response (OKAY/ERROR/RETRY/SPLIT)
//   - ds_state_t  : default-slave FSM state
//   - addr_hit()  : masked base-address compare used by the decoder
// -----------------------------------------------------------------------------
package ahb_decoder_ds_pkg;

    // Widest address the compare helper handles; callers zero-extend into it.
    localparam int AHB_AW_MAX = 64;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY   = 2'b01,
        NONSEQ = 2'b10,
        SEQ    = 2'b11
    } htrans_type;

    typedef enum logic [1:0] {
        OKAY  = 2'b00,
        ERROR = 2'b01,
        RETRY = 2'b10,
        SPLIT = 2'b11
    } hresp_type;

    typedef enum logic [1:0] {
        DS_IDLE = 2'b00,
        DS_ERR1 = 2'b01,
        DS_ERR2 = 2'b10
    } ds_state_t;

    // True when the masked address equals the region base.
    function automatic logic addr_hit(
        input logic [AHB_AW_MAX-1:0] addr,
        input logic [AHB_AW_MAX-1:0] base,
        input logic [AHB_AW_MAX-1:0] mask
    );
        return ((addr & mask) == base);
    endfunction

endpackage

// File: rtl/ahb_decoder_ds_default_slave.sv
// -----------------------------------------------------------------------------
// ahb_default_slave
//   Default slave for unmapped NONSEQ/SEQ accesses. Answers each one with a
//   two-cycle AHB ERROR response and keeps error bookkeeping.
//
// Ports
//   hclk, hreset   clock / synchronous active-high reset
//   hready         bus hready (response mux output)
//   dflt_hit       address phase targets no region and is NONSEQ/SEQ
//   haddr          address-phase address (captured on the first error)
//   err_clr        clears err_cnt and the err_addr valid flag
//   dflt_hready    default-slave hreadyout
//   dflt_hresp     default-slave response
//   err_addr       address of the first unmapped access since clear
//   err_cnt        saturating count of error events
//   ds_state       current FSM state (debug visibility)
//
// FSM
//   DS_IDLE : ready/OKAY. hready & dflt_hit -> DS_ERR1 (error event)
//   DS_ERR1 : not ready/ERROR -> DS_ERR2
//   DS_ERR2 : ready/ERROR. dflt_hit -> DS_ERR1 (error event), else DS_IDLE
//   In DS_ERR2 the bus hready is this slave's own ready (=1), so the pending
//   address phase completes in that cycle without re-qualifying on hready.
// -----------------------------------------------------------------------------
module ahb_default_slave
    import ahb_decoder_ds_pkg::*;
#(
    parameter int AHB_ADDR_WIDTH = 32,
    parameter int ERR_CNT_W      = 8
) (
    input  logic                      hclk,
    input  logic                      hreset,
    input  logic                      hready,
    input  logic                      dflt_hit,
    input  logic [AHB_ADDR_WIDTH-1:0] haddr,
    input  logic                      err_clr,
    output logic                      dflt_hready,
    output hresp_type                 dflt_hresp,
    output logic [AHB_ADDR_WIDTH-1:0] err_addr,
    output logic [ERR_CNT_W-1:0]      err_cnt,
    output ds_state_t                 ds_state
);

    ds_state_t                 state_q, state_d;
    logic [ERR_CNT_W-1:0]      err_cnt_q, err_cnt_d;
    logic [AHB_ADDR_WIDTH-1:0] err_addr_q, err_addr_d;
    logic                      err_vld_q, err_vld_d;
    logic                      err_evt;

    // Next-state and error-event decode.
    always_comb begin
        state_d = state_q;
        err_evt = 1'b0;
        case (state_q)
            DS_IDLE: begin
                if (hready && dflt_hit) begin
                    state_d = DS_ERR1;
                    err_evt = 1'b1;
                end
            end
            DS_ERR1: begin
                state_d = DS_ERR2;
            end
            DS_ERR2: begin
                if (dflt_hit) begin
                    state_d = DS_ERR1;
                    err_evt = 1'b1;
                end else begin
                    state_d = DS_IDLE;
                end
            end
            default: begin
                state_d = DS_IDLE;
            end
        endcase
    end

    // Error bookkeeping. err_clr wins over a same-cycle event for the count;
    // the event still captures its address, making it the first error after
    // the clear, so the valid flag ends up set.
    always_comb begin
        err_cnt_d  = err_cnt_q;
        err_addr_d = err_addr_q;
        err_vld_d  = err_vld_q;
        if (err_clr) begin
            err_cnt_d = '0;
            err_vld_d = 1'b0;
        end else if (err_evt && (err_cnt_q != {ERR_CNT_W{1'b1}})) begin
            err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
        end
        if (err_evt) begin
            if (!err_vld_q || err_clr) begin
                err_addr_d = haddr;
            end
            err_vld_d = 1'b1;
        end
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            state_q    <= DS_IDLE;
            err_cnt_q  <= '0;
            err_addr_q <= '0;
            err_vld_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            err_cnt_q  <= err_cnt_d;
            err_addr_q <= err_addr_d;
            err_vld_q  <= err_vld_d;
        end
    end

    // Response is a pure function of state.
    assign dflt_hready = (state_q != DS_ERR1);
    assign dflt_hresp  = (state_q == DS_IDLE) ? OKAY : ERROR;
    assign err_cnt     = err_cnt_q;
    assign err_addr    = err_addr_q;
    assign ds_state    = state_q;

endmodule

// File: rtl/ahb_decoder_ds.sv
// -----------------------------------------------------------------------------
// ahb_decoder_ds
//   AHB address decoder with a built-in default slave, one per master.
//   Decodes haddr against SLV_NUM base/mask regions into a one-hot hsel,
//   registers the data-phase selects that steer the response mux, and
//   answers unmapped NONSEQ/SEQ accesses with a two-cycle ERROR.
//
// Ports
//   hclk, hreset   clock / synchronous active-high reset
//   haddr, htrans  address-phase address and transfer type
//   hremap         (AHB_DEC_REMAP_EN only) swap region 0 with REMAP_SLV
//   hready         bus hready (response mux output)
//   hsel           combinational address-phase one-hot select
//   hsel_dp        registered data-phase slave select
//   dflt_sel_dp    registered data-phase default-slave select
//   dflt_hready    default-slave hreadyout
//   dflt_hresp     default-slave response
//   err_addr       address of the first unmapped access since clear
//   err_cnt        saturating unmapped-access count
//   err_clr        clears err_cnt and the err_addr valid flag
//
// Build option
//   AHB_DEC_REMAP_EN : adds hremap. When set, region 0 and region REMAP_SLV
//   exchange base/mask for decode; hsel bit positions are not renumbered.
//   Without it the map is fixed and there is no hremap port.
//
// Handshake: an address phase is accepted on a rising edge where hready=1;
// only then do hsel_dp/dflt_sel_dp take the new select, otherwise they hold.
// -----------------------------------------------------------------------------
module ahb_decoder_ds
    import ahb_decoder_ds_pkg::*;
#(
    parameter int AHB_ADDR_WIDTH = 32,
    parameter int SLV_NUM        = 4,
    parameter logic [SLV_NUM*AHB_ADDR_WIDTH-1:0] SLV_BASE = {SLV_NUM{32'h0}},
    parameter logic [SLV_NUM*AHB_ADDR_WIDTH-1:0] SLV_MASK = {SLV_NUM{32'hFFFF_0000}},
    parameter int ERR_CNT_W      = 8
`ifdef AHB_DEC_REMAP_EN
    ,
    parameter int REMAP_SLV      = 1
`endif
) (
    input  logic                      hclk,
    input  logic                      hreset,
    input  logic [AHB_ADDR_WIDTH-1:0] haddr,
    input  htrans_type                htrans,
`ifdef AHB_DEC_REMAP_EN
    input  logic                      hremap,
`endif
    input  logic                      hready,
    output logic [SLV_NUM-1:0]        hsel,
    output logic [SLV_NUM-1:0]        hsel_dp,
    output logic                      dflt_sel_dp,
    output logic                      dflt_hready,
    output hresp_type                 dflt_hresp,
    output logic [AHB_ADDR_WIDTH-1:0] err_addr,
    output logic [ERR_CNT_W-1:0]      err_cnt,
    input  logic                      err_clr
);

    localparam int AW = AHB_ADDR_WIDTH;

    logic [AW-1:0]         eff_base [SLV_NUM];
    logic [AW-1:0]         eff_mask [SLV_NUM];
    logic [AHB_AW_MAX-1:0] addr_ext;
    logic [AHB_AW_MAX-1:0] base_ext;
    logic [AHB_AW_MAX-1:0] mask_ext;
    logic [SLV_NUM-1:0]    raw_hit;
    logic [SLV_NUM-1:0]    hit;
    logic                  hit_found;
    logic                  act;
    logic                  dflt_hit;

    logic [SLV_NUM-1:0]    hsel_dp_q, hsel_dp_d;
    logic                  dflt_sel_dp_q, dflt_sel_dp_d;

    ds_state_t             ds_state;

`ifdef AHB_DEC_REMAP_EN
    // An out-of-range REMAP_SLV collapses to region 0, i.e. remap is a no-op.
    localparam int REMAP_IDX = (REMAP_SLV < SLV_NUM) ? REMAP_SLV : 0;
`endif

    // Effective region table, optionally with region 0 and REMAP_IDX swapped.
    always_comb begin
        for (int i = 0; i < SLV_NUM; i++) begin
            eff_base[i] = SLV_BASE[i*AW +: AW];
            eff_mask[i] = SLV_MASK[i*AW +: AW];
        end
`ifdef AHB_DEC_REMAP_EN
        if (hremap) begin
            eff_base[0]         = SLV_BASE[REMAP_IDX*AW +: AW];
            eff_mask[0]         = SLV_MASK[REMAP_IDX*AW +: AW];
            eff_base[REMAP_IDX] = SLV_BASE[0 +: AW];
            eff_mask[REMAP_IDX] = SLV_MASK[0 +: AW];
        end
`endif
    end

    // Raw per-region compare.
    always_comb begin
        addr_ext           = '0;
        addr_ext[AW-1:0]   = haddr;
        base_ext           = '0;
        mask_ext           = '0;
        raw_hit            = '0;
        for (int i = 0; i < SLV_NUM; i++) begin
            base_ext         = '0;
            mask_ext         = '0;
            base_ext[AW-1:0] = eff_base[i];
            mask_ext[AW-1:0] = eff_mask[i];
            raw_hit[i]       = addr_hit(addr_ext, base_ext, mask_ext);
        end
    end

    // Overlapping regions: lowest index wins so hit is always one-hot.
    always_comb begin
        hit       = '0;
        hit_found = 1'b0;
        for (int i = 0; i < SLV_NUM; i++) begin
            if (raw_hit[i] && !hit_found) begin
                hit[i]    = 1'b1;
                hit_found = 1'b1;
            end
        end
    end

    // BUSY still selects a mapped slave, but only NONSEQ/SEQ can raise an
    // error, so BUSY/IDLE to an unmapped address is silently ignored.
    assign act      = (htrans == NONSEQ) || (htrans == SEQ);
    assign hsel     = (htrans != IDLE) ? hit : '0;
    assign dflt_hit = act && !hit_found;

    // Data-phase selects advance only when the bus accepts the address phase.
    always_comb begin
        hsel_dp_d     = hsel_dp_q;
        dflt_sel_dp_d = dflt_sel_dp_q;
        if (hready) begin
            hsel_dp_d     = hsel;
            dflt_sel_dp_d = dflt_hit;
        end
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            hsel_dp_q     <= '0;
            dflt_sel_dp_q <= 1'b0;
        end else begin
            hsel_dp_q     <= hsel_dp_d;
            dflt_sel_dp_q <= dflt_sel_dp_d;
        end
    end

    assign hsel_dp     = hsel_dp_q;
    assign dflt_sel_dp = dflt_sel_dp_q;

    ahb_default_slave #(
        .AHB_ADDR_WIDTH (AHB_ADDR_WIDTH),
        .ERR_CNT_W      (ERR_CNT_W)
    ) u_dflt_slave (
        .hclk        (hclk),
        .hreset      (hreset),
        .hready      (hready),
        .dflt_hit    (dflt_hit),
        .haddr       (haddr),
        .err_clr     (err_clr),
        .dflt_hready (dflt_hready),
        .dflt_hresp  (dflt_hresp),
        .err_addr    (err_addr),
        .err_cnt     (err_cnt),
        .ds_state    (ds_state)
    );

endmodule

// File: tb/tb_ahb_decoder_ds.sv
// -----------------------------------------------------------------------------
// tb_ahb_decoder_ds
//   Self-checking bench for ahb_decoder_ds: 4 regions at 0x0000_0000,
//   0x0001_0000, 0x0002_0000, 0x0003_0000 with mask 0xFFFF_0000.
//   Define AHB_DEC_REMAP_EN to exercise hremap.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ahb_decoder_ds;
    import ahb_decoder_ds_pkg::*;

    localparam int AW = 32;
    localparam int SN = 4;
    localparam int CW = 8;
    localparam logic [SN*AW-1:0] BASES = {32'h0003_0000, 32'h0002_0000,
                                          32'h0001_0000, 32'h0000_0000};
    localparam logic [SN*AW-1:0] MASKS = {SN{32'hFFFF_0000}};

    // ---------------- clock / reset ----------------
    logic hclk = 1'b0;
    logic hreset;
    always #5 hclk = ~hclk;

    logic [AW-1:0] haddr;
    htrans_type    htrans;
    logic          hready;
    logic          err_clr;
    logic          remap_on;
`ifdef AHB_DEC_REMAP_EN
    logic          hremap;
`endif
    logic [SN-1:0] hsel;
    logic [SN-1:0] hsel_dp;
    logic          dflt_sel_dp;
    logic          dflt_hready;
    hresp_type     dflt_hresp;
    logic [AW-1:0] err_addr;
    logic [CW-1:0] err_cnt;

    ahb_decoder_ds #(
        .AHB_ADDR_WIDTH (AW),
        .SLV_NUM        (SN),
        .SLV_BASE       (BASES),
        .SLV_MASK       (MASKS),
        .ERR_CNT_W      (CW)
    ) dut (
        .hclk        (hclk),
        .hreset      (hreset),
        .haddr       (haddr),
        .htrans      (htrans),
`ifdef AHB_DEC_REMAP_EN
        .hremap      (hremap),
`endif
        .hready      (hready),
        .hsel        (hsel),
        .hsel_dp     (hsel_dp),
        .dflt_sel_dp (dflt_sel_dp),
        .dflt_hready (dflt_hready),
        .dflt_hresp  (dflt_hresp),
        .err_addr    (err_addr),
        .err_cnt     (err_cnt),
        .err_clr     (err_clr)
    );

    // ---------------- scoreboard ----------------
    int          n_checks;
    int          n_pass;
    logic [4:0]  exp_q[$];   // {dflt_sel, hsel[3:0]} expected in data phase
    logic [4:0]  last_dp;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Reference decode: region r covers addr[31:16] == r for r in 0..3.
    function automatic logic [4:0] model_sel(input logic [31:0] a, input htrans_type t,
                                             input logic rm);
        logic [3:0] s;
        logic       d;
        int         r;
        s = 4'b0000;
        d = 1'b0;
        if (a[31:18] == 14'd0) begin
            r = int'(a[17:16]);
            if (rm && (r <= 1)) r = 1 - r;
            if (t != IDLE) s[r] = 1'b1;
        end else begin
            d = (t == NONSEQ) || (t == SEQ);
        end
        return {d, s};
    endfunction

    // ---------------- driver tasks ----------------
    // One bus cycle: drive at negedge, check comb hsel, then check the
    // registered data-phase select after the rising edge.
    task automatic tick(input logic [31:0] a, input htrans_type t, input logic rdy,
                        input logic clr);
        logic [4:0] exp_now;
        @(negedge hclk);
        haddr   = a;
        htrans  = t;
        hready  = rdy;
        err_clr = clr;
`ifdef AHB_DEC_REMAP_EN
        hremap  = remap_on;
`endif
        #1;
        exp_now = model_sel(a, t, remap_on);
        check("hsel", {28'd0, hsel}, {28'd0, exp_now[3:0]});
        if (rdy) exp_q.push_back(exp_now);
        @(posedge hclk);
        #1;
        if (rdy) begin
            check("dp_queue", exp_q.size(), 1);
            if (exp_q.size() > 0) last_dp = exp_q.pop_front();
        end
        check("hsel_dp", {27'd0, dflt_sel_dp, hsel_dp}, {27'd0, last_dp});
    endtask

    task automatic check_ds(input string tag, input logic rdy, input hresp_type resp);
        check({tag, "_hready"}, {31'd0, dflt_hready}, {31'd0, rdy});
        check({tag, "_hresp"}, 32'(dflt_hresp), 32'(resp));
    endtask

    task automatic reset_pulse(input string tag);
        @(negedge hclk);
        hreset  = 1'b1;
        haddr   = '0;
        htrans  = IDLE;
        hready  = 1'b1;
        err_clr = 1'b0;
        @(posedge hclk);
        #1;
        exp_q.delete();
        last_dp = 5'd0;
        check({tag, "_hsel_dp"}, {28'd0, hsel_dp}, 32'd0);
        check({tag, "_dflt_sel_dp"}, {31'd0, dflt_sel_dp}, 32'd0);
        check({tag, "_err_cnt"}, {24'd0, err_cnt}, 32'd0);
        check({tag, "_err_addr"}, err_addr, 32'd0);
        check_ds(tag, 1'b1, OKAY);
        @(negedge hclk);
        hreset = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    logic [31:0] a;

    initial begin
        n_checks = 0;
        n_pass   = 0;
        remap_on = 1'b0;
        last_dp  = 5'd0;
        hreset   = 1'b1;
        haddr    = '0;
        htrans   = IDLE;
        hready   = 1'b1;
        err_clr  = 1'b0;
`ifdef AHB_DEC_REMAP_EN
        hremap   = 1'b0;
`endif
        reset_pulse("rst");

        // T1: mapped NONSEQ
        tick(32'h0002_0040, NONSEQ, 1'b1, 1'b0);
        check("t1_hsel_dp", {28'd0, hsel_dp}, 32'h4);
        tick(32'h0000_0000, IDLE, 1'b1, 1'b0);

        // T2: single unmapped access, 2-cycle error
        tick(32'h0009_0000, NONSEQ, 1'b1, 1'b0);
        check("t2_dflt_sel", {31'd0, dflt_sel_dp}, 32'd1);
        check_ds("t2_err1", 1'b0, ERROR);
        tick(32'h0000_0000, IDLE, 1'b0, 1'b0);
        check_ds("t2_err2", 1'b1, ERROR);
        tick(32'h0000_0000, IDLE, 1'b1, 1'b0);
        check_ds("t2_done", 1'b1, OKAY);
        check("t2_err_cnt", {24'd0, err_cnt}, 32'd1);
        check("t2_err_addr", err_addr, 32'h0009_0000);

        // err_clr alone: count zeroed, address register kept
        tick(32'h0000_0000, IDLE, 1'b1, 1'b1);
        check("clr_err_cnt", {24'd0, err_cnt}, 32'd0);
        check("clr_err_addr", err_addr, 32'h0009_0000);

        // T3: error, then a mapped phase, then a 3-cycle stall, then error
        tick(32'h0005_0000, NONSEQ, 1'b1, 1'b0);
        check("t3_first_addr", err_addr, 32'h0005_0000);
        tick(32'h0001_0000, NONSEQ, 1'b0, 1'b0);
        tick(32'h0001_0000, NONSEQ, 1'b1, 1'b0);
        check_ds("t3_to_idle", 1'b1, OKAY);
        for (int k = 0; k < 3; k++) begin
            tick(32'h0007_0000, NONSEQ, 1'b0, 1'b0);
            check("t3_hold_dp", {28'd0, hsel_dp}, 32'h2);
            check("t3_hold_cnt", {24'd0, err_cnt}, 32'd1);
        end
        tick(32'h0007_0000, NONSEQ, 1'b1, 1'b0);
        check_ds("t3_err1", 1'b0, ERROR);
        tick(32'h0000_0000, IDLE, 1'b0, 1'b0);
        tick(32'h0000_0000, IDLE, 1'b1, 1'b0);
        check_ds("t3_done", 1'b1, OKAY);
        check("t3_err_cnt", {24'd0, err_cnt}, 32'd2);
        check("t3_err_addr", err_addr, 32'h0005_0000);

        // T4: 300 pipelined unmapped accesses saturate the counter
        tick(32'h0010_0000, NONSEQ, 1'b1, 1'b0);
        for (int k = 1; k < 300; k++) begin
            a = {4'h8, 12'($urandom_range(0, 4095)), 16'h0000};
            tick(a, NONSEQ, 1'b0, 1'b0);
            tick(a, NONSEQ, 1'b1, 1'b0);
        end
        check("t4_sat", {24'd0, err_cnt}, 32'h0000_00FF);
        check_ds("t4_err1", 1'b0, ERROR);
        tick(32'h00AB_0000, NONSEQ, 1'b0, 1'b0);
        tick(32'h00AB_0000, NONSEQ, 1'b1, 1'b1);
        check("t4_clr_cnt", {24'd0, err_cnt}, 32'd0);
        check("t4_clr_addr", err_addr, 32'h00AB_0000);
        tick(32'h0000_0000, IDLE, 1'b0, 1'b0);
        tick(32'h0000_0000, IDLE, 1'b1, 1'b0);
        check_ds("t4_done", 1'b1, OKAY);
        check("t4_cnt_after", {24'd0, err_cnt}, 32'd0);

        // T5: reset while in DS_ERR1, then BUSY/IDLE to unmapped
        tick(32'h0009_0000, NONSEQ, 1'b1, 1'b0);
        check_ds("t5_err1", 1'b0, ERROR);
        reset_pulse("t5_rst");
        tick(32'h0009_0000, BUSY, 1'b1, 1'b0);
        check_ds("t5_busy", 1'b1, OKAY);
        tick(32'h0009_0000, IDLE, 1'b1, 1'b0);
        check_ds("t5_idle", 1'b1, OKAY);
        check("t5_err_cnt", {24'd0, err_cnt}, 32'd0);
        tick(32'h0003_0004, BUSY, 1'b1, 1'b0);
        check("t5_busy_map", {28'd0, hsel_dp}, 32'h8);
        tick(32'h0003_0008, SEQ, 1'b1, 1'b0);
        tick(32'h0000_0000, IDLE, 1'b1, 1'b0);

`ifdef AHB_DEC_REMAP_EN
        // T6: remap swaps region 0 and region 1
        remap_on = 1'b1;
        tick(32'h0000_0010, NONSEQ, 1'b1, 1'b0);
        check("t6_remap_dp", {28'd0, hsel_dp}, 32'h2);
        remap_on = 1'b0;
        tick(32'h0000_0010, NONSEQ, 1'b1, 1'b0);
        check("t6_plain_dp", {28'd0, hsel_dp}, 32'h1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Safety net against a stuck run.
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
